dm_responder: RTL and testbench
===============================

# dm_responder

Memory-side responder for the processor's data-memory port: accepts load/store requests over a valid/ready handshake, inserts a programmable number of wait states, and returns the read word or a write acknowledgement over a second valid/ready channel. It is the target side of the CPU data interface and replaces the zero-latency `dm_1k` for multi-cycle memory experiments. Storage is internal: `DEPTH_WORDS` 32-bit words.

## Interface
- `WAIT_CYCLES`, default 2: wait states between accept and response; legal range 0..15.
- `DEPTH_WORDS`, default 256: word capacity; word index = `req_addr[9:2]`, taken modulo `DEPTH_WORDS`.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept; high only in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  10  byte address.
- `req_wdata`  in  32  store data.
- `req_be`  in  4  byte enables; used only with `DMR_BYTE_LANE_EN`, otherwise ignored.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  requester consumes response.
- `rsp_rdata`  out  32  load data; 0 for stores and errored requests.
- `rsp_err`  out  1  request rejected; no memory side effect.
- `busy`  out  1  high in WAIT or RESP.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `req_ready`=1. On `req_valid && req_ready`, latch `we`, `addr`, `wdata`, `be`. Go to WAIT with the counter loaded to `WAIT_CYCLES-1`. If `WAIT_CYCLES`=0, go directly to RESP and perform the commit at that same edge.
- WAIT: decrement the counter each cycle. At counter 0, commit and go to RESP.
- Commit (one edge):
  - Store: write the word, or enabled lanes only.
  - Load: register the word into `rsp_rdata`.
  - Set `rsp_err` per the rules below.
- RESP: `rsp_valid`=1. Hold `rsp_rdata` and `rsp_err` stable until `rsp_valid && rsp_ready`, then go to IDLE. On that exit edge, clear `rsp_rdata` and `rsp_err` to 0.
- Only one transaction is ever outstanding. `req_ready`=0 in WAIT and RESP, so no request is accepted while a response is pending.
- Error rule without the macro: `req_addr[1:0]`≠0 gives `rsp_err`=1, no write, `rsp_rdata`=0.
- Memory array is not cleared by reset.

## Timing
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `busy`=0, counter=0.
- Latency: request accepted at edge N gives `rsp_valid`=1 from cycle N+`WAIT_CYCLES`+1.
- Throughput with `rsp_ready` tied high: one transaction every `WAIT_CYCLES`+2 cycles.
- `req_ready`, `rsp_valid`, `busy` decode from registered state only; no combinational path from inputs.
- Store visible to a load accepted at any later cycle.
- Reset mid-operation:
  - Asserted in WAIT before commit: the pending store is dropped.
  - Asserted in RESP: the response is discarded.
  - The next cycle is IDLE in both cases.
- `req_valid` deasserted in IDLE: no state change. Request fields outside the accept edge are don't-care.

## Configuration
- `DMR_BYTE_LANE_EN` defined:
  - `req_be` is honored; store writes only lanes with `be[i]`=1.
  - Load returns the full word.
  - `req_addr[1:0]` is ignored.
  - `rsp_err`=1 iff `req_be`=4'b0000.
- Not defined:
  - Full-word access only; `req_be` is ignored.
  - Misaligned address gives an error per Operation.

## Test plan
- Reset then idle: hold `rst`=1 two cycles → `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `busy`=0.
- Store then load, `WAIT_CYCLES`=2, `rsp_ready`=1:
  - Store 32'hDEADBEEF to addr 10'h010 → `rsp_valid` 3 cycles after accept, `rsp_rdata`=0.
  - Load addr 10'h010 → `rsp_rdata`=32'hDEADBEEF.
- Backpressure: hold `rsp_ready`=0 for 5 cycles in RESP → `rsp_valid` and `rsp_rdata` stable, `req_ready`=0 throughout. Response completes on the first `rsp_ready`=1.
- Misaligned load to 10'h013 (macro off) → `rsp_err`=1, `rsp_rdata`=0, memory unchanged.
- Reset during WAIT of store 32'h12345678 to 10'h020 → later load from 10'h020 returns the prior contents.
- With `DMR_BYTE_LANE_EN`:
  - Store 32'hAABBCCDD, `be`=4'b0101, over word 32'h0 → load returns 32'h00BB00DD.
  - `be`=0 → `rsp_err`=1.

Source files
------------

// File: rtl/dm_responder_if.sv
// Request/response channel between the CPU data port and dm_responder.
// master = CPU side, slave = responder side.
interface dm_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/dm_responder.sv
// Data-memory responder: one outstanding load/store, WAIT_CYCLES wait states, internal storage.
// Define DMR_BYTE_LANE_EN to honour req_be (byte-lane stores, error only when be is zero).
module dm_responder #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned DEPTH_WORDS = 256
) (
    input logic          clk,
    input logic          rst,
    dm_responder_if.slave bus
);
    localparam int unsigned IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam bit ZeroWait = (WAIT_CYCLES == 0);
    localparam logic [3:0] WaitLoad = ZeroWait ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [9:0]  addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic          accept;
    logic          commit;
    logic          c_we;
    logic [9:0]    c_addr;
    logic [31:0]   c_wdata;
    logic [3:0]    c_be;
    logic          c_err;
    logic [3:0]    c_mask;
    logic [IW-1:0] c_idx;
    logic          mem_we;

    assign accept = bus.req_valid && (state_q == StIdle);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        c_we    = we_q;
        c_addr  = addr_q;
        c_wdata = wdata_q;
        c_be    = be_q;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    if (ZeroWait) begin
                        // No wait states: commit straight from the bus at the accept edge.
                        commit  = 1'b1;
                        c_we    = bus.req_we;
                        c_addr  = bus.req_addr;
                        c_wdata = bus.req_wdata;
                        c_be    = bus.req_be;
                        state_d = StResp;
                    end else begin
                        cnt_d   = WaitLoad;
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    commit  = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef DMR_BYTE_LANE_EN
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^c_addr[1:0];
    assign c_err  = (c_be == 4'b0000);
    assign c_mask = c_be;
`else
    logic unused_be;
    assign unused_be = ^c_be;
    assign c_err  = (c_addr[1:0] != 2'b00);
    assign c_mask = 4'hF;
`endif

    assign c_idx  = IW'(32'(c_addr[9:2]) % DEPTH_WORDS);
    assign mem_we = commit && c_we && !c_err;

    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (commit) begin
            err_d   = c_err;
            rdata_d = (c_we || c_err) ? 32'd0 : mem[c_idx];
        end else if (state_q == StResp && bus.rsp_ready) begin
            rdata_d = 32'd0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 10'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                we_q    <= bus.req_we;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                be_q    <= bus.req_be;
            end
        end
    end

    // Storage is never cleared; a commit coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (c_mask[i]) begin
                    mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.req_ready = (state_q == StIdle);
    assign bus.rsp_valid = (state_q == StResp);
    assign bus.busy      = (state_q != StIdle);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder; expectations are hand-computed constants.
module tb_dm_responder;
    localparam int unsigned W = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dm_responder_if bus();

    dm_responder #(
        .WAIT_CYCLES(W),
        .DEPTH_WORDS(256)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full transaction; stall = cycles of rsp_ready=0 held while in RESP.
    task automatic xact(input string tag, input logic we, input logic [9:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input int stall,
                        input logic [31:0] exp_rdata, input logic exp_err);
        int lat;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_be    = be;
        bus.rsp_ready = (stall == 0);
        check({tag, "/req_ready"}, 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        // Scramble fields after accept so unlatched use shows up.
        bus.req_valid = 1'b0;
        bus.req_we    = ~we;
        bus.req_addr  = ~addr;
        bus.req_wdata = ~wdata;
        bus.req_be    = ~be;
        lat = 1;
        check({tag, "/busy"}, 32'(bus.busy), 32'd1);
        check({tag, "/req_ready_low"}, 32'(bus.req_ready), 32'd0);
        while (!bus.rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "/latency"}, 32'(lat), 32'(W + 1));
        for (int i = 0; i < stall; i++) begin
            check({tag, "/hold_valid"}, 32'(bus.rsp_valid), 32'd1);
            check({tag, "/hold_rdata"}, bus.rsp_rdata, exp_rdata);
            check({tag, "/hold_req_ready"}, 32'(bus.req_ready), 32'd0);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        check({tag, "/rdata"}, bus.rsp_rdata, exp_rdata);
        check({tag, "/err"}, 32'(bus.rsp_err), 32'(exp_err));
        @(negedge clk);
        check({tag, "/done_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, "/done_rdata"}, bus.rsp_rdata, 32'd0);
        check({tag, "/done_err"}, 32'(bus.rsp_err), 32'd0);
        check({tag, "/done_busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int acc[$];

        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 10'd0;
        bus.req_wdata = 32'd0;
        bus.req_be    = 4'd0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset/req_ready", 32'(bus.req_ready), 32'd1);
        check("reset/rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset/rsp_rdata", bus.rsp_rdata, 32'd0);
        check("reset/rsp_err", 32'(bus.rsp_err), 32'd0);
        check("reset/busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;

        repeat (3) @(negedge clk);
        check("idle/req_ready", 32'(bus.req_ready), 32'd1);
        check("idle/busy", 32'(bus.busy), 32'd0);

        xact("st10", 1'b1, 10'h010, 32'hDEADBEEF, 4'hF, 0, 32'd0, 1'b0);
        xact("ld10", 1'b0, 10'h010, 32'h0, 4'hF, 0, 32'hDEADBEEF, 1'b0);
        xact("st20", 1'b1, 10'h020, 32'h11111111, 4'hF, 0, 32'd0, 1'b0);
        xact("bp_ld10", 1'b0, 10'h010, 32'h0, 4'hF, 5, 32'hDEADBEEF, 1'b0);

`ifdef DMR_BYTE_LANE_EN
        xact("ld13", 1'b0, 10'h013, 32'h0, 4'hF, 0, 32'hDEADBEEF, 1'b0);
        xact("st10_be0", 1'b1, 10'h010, 32'hCAFEF00D, 4'h0, 0, 32'd0, 1'b1);
        xact("ld10_after_be0", 1'b0, 10'h010, 32'h0, 4'hF, 0, 32'hDEADBEEF, 1'b0);
        xact("st30_zero", 1'b1, 10'h030, 32'h0, 4'hF, 0, 32'd0, 1'b0);
        xact("st30_lanes", 1'b1, 10'h030, 32'hAABBCCDD, 4'b0101, 0, 32'd0, 1'b0);
        xact("ld30", 1'b0, 10'h030, 32'h0, 4'hF, 0, 32'h00BB00DD, 1'b0);
        xact("st33_lane3", 1'b1, 10'h033, 32'h77000000, 4'b1000, 0, 32'd0, 1'b0);
        xact("ld30_b", 1'b0, 10'h030, 32'h0, 4'hF, 0, 32'h77BB00DD, 1'b0);
`else
        xact("ld13_mis", 1'b0, 10'h013, 32'h0, 4'hF, 0, 32'd0, 1'b1);
        xact("st11_mis", 1'b1, 10'h011, 32'hCAFEF00D, 4'hF, 0, 32'd0, 1'b1);
        xact("ld10_after_mis", 1'b0, 10'h010, 32'h0, 4'hF, 0, 32'hDEADBEEF, 1'b0);
        xact("st30_be_ign", 1'b1, 10'h030, 32'hAABBCCDD, 4'b0101, 0, 32'd0, 1'b0);
        xact("ld30", 1'b0, 10'h030, 32'h0, 4'hF, 0, 32'hAABBCCDD, 1'b0);
`endif

        // Reset while the store to 0x020 is still waiting: the write must be dropped.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 10'h020;
        bus.req_wdata = 32'h12345678;
        bus.req_be    = 4'hF;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("rst_wait/in_wait", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_wait/req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_wait/rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_wait/busy", 32'(bus.busy), 32'd0);
        xact("ld20_after_rst", 1'b0, 10'h020, 32'h0, 4'hF, 0, 32'h11111111, 1'b0);

        // Reset in RESP: response discarded, but the commit already happened.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 10'h010;
        bus.req_be    = 4'hF;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("rst_resp/latency", 32'(lat), 32'(W + 1));
        check("rst_resp/rdata", bus.rsp_rdata, 32'hDEADBEEF);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_resp/rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_resp/rdata_clr", bus.rsp_rdata, 32'd0);
        check("rst_resp/req_ready", 32'(bus.req_ready), 32'd1);

        // Back-to-back loads with rsp_ready high: accepts every W+2 cycles.
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 10'h010;
        bus.req_be    = 4'hF;
        for (int i = 0; i < 20; i++) begin
            if (bus.req_ready) acc.push_back(i);
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        check("tput/gap0", 32'((acc.size() >= 2) ? acc[1] - acc[0] : 0), 32'(W + 2));
        check("tput/gap1", 32'((acc.size() >= 3) ? acc[2] - acc[1] : 0), 32'(W + 2));
        lat = 0;
        while (bus.busy && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("tput/drain", 32'(bus.busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
